control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit that drives the Datapath control inputs through fetch (T0-T2) and execute (T3-T6) steps.
//  It supports 3-register ALU ops, 2-register mul/div, nop and halt.
//  Sits beside Datapath. It reads the IR contents and drives every *_out / *_enable strobe, Read, IncPC and the ALU opcode.
//  Replaces hand-sequenced strobes; memory handshake via mem_ready with timeout.
// PARAMETERS
//  TIMEOUT   255  max cycles waiting in T1 for mem_ready before FAULT
//  CNT_W     8    width of wait counter (must hold TIMEOUT)
// PORTS
//  clk        in   1   clock, all state changes on rising edge
//  clr        in   1   synchronous active-high reset
//  start      in   1   begin fetching when in IDLE
//  stop       in   1   finish current instruction, then IDLE
//  mem_ready  in   1   memory data valid on Mdatain this cycle
//  IR         in   32  Datapath IR; [31:27] op, [26:23] Ra, [22:19] Rb, [18:15] Rc
//  PC_out, IncPC, PC_enable, MAR_enable      out 1 each  PC/MAR strobes
//  Read, MDR_enable, MDR_out, IR_enable      out 1 each  memory/IR strobes
//  Y_enable, Z_enable, ZLow_out, ZHigh_out   out 1 each  ALU operand/result strobes
//  HI_enable, LO_enable                      out 1 each  HI/LO load
//  R_out      out  16  one-hot register-to-bus select (R_out[n] -> Rn_out)
//  R_enable   out  16  one-hot register load (R_enable[n] -> Rn_enable)
//  opcode     out  5   ALU op to Datapath; 0 except in T4
//  busy       out  1   state not IDLE/HALTED/FAULT
//  halted     out  1   in HALTED
//  fault      out  1   in FAULT
//  instr_done out  1   1-cycle pulse in last execute step of each instruction
// BEHAVIOUR
//  States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED, FAULT. Outputs are Moore decodes of the state and the IR fields.
//  On clr: state=IDLE, wait counter=0, stop_pending=0 -> every output 0 next cycle. clr mid-instruction aborts it.
//  IDLE: outputs 0. start&!stop -> T0. start&stop in the same cycle -> stay IDLE.
//  T0: PC_out, MAR_enable, IncPC, PC_enable=1 -> T1.
//  T1: Read, MDR_enable=1. mem_ready -> T2, counter cleared.
//   !mem_ready: counter+1. Counter reaching TIMEOUT with mem_ready still 0 -> FAULT.
//   mem_ready on the TIMEOUT cycle wins -> T2.
//  T2: MDR_out, IR_enable=1 -> T3. The IR is valid from T3 onward.
//  Op classes by IR[31:27]:
//   ALU = 5'b00000-5'b01110 (add, sub, and, or, shr, shra, shl, ror, rol, ...)
//   MULDIV = 5'b01111 mul, 5'b10000 div
//   NOP = 5'b11010
//   HALT = 5'b11011
//   every other value -> NOP handling.
//  ALU path:
//   T3: R_out[Rb], Y_enable.
//   T4: R_out[Rc], Z_enable, opcode=IR[31:27].
//   T5: ZLow_out, R_enable[Ra], instr_done.
//  MULDIV path:
//   T3: R_out[Ra], Y_enable.
//   T4: R_out[Rb], Z_enable, opcode=IR[31:27].
//   T5: ZLow_out, LO_enable.
//   T6: ZHigh_out, HI_enable, instr_done.
//  NOP path: T3 asserts only instr_done.
//  HALT path: T3 -> HALTED, instr_done=1. HALTED and FAULT exit only via clr.
//  After the final step: stop_pending|stop -> IDLE (stop_pending cleared), else -> T0.
//  stop sampled in any busy state sets stop_pending; it never truncates an instruction.
//  R_out and R_enable are never multi-hot. Ra/Rb/Rc==0 selects R0 normally, with no special casing.
//  Exactly one bus driver is active per cycle. No strobe is asserted in IDLE, HALTED or FAULT.
// TESTING
//  1 ALU: IR=32'h40090000 (shr, Ra=0 Rb=1 Rc=2), mem_ready in T1.
//    Required: T3 R_out=16'h0002 + Y_enable; T4 R_out=16'h0004 + opcode=5'b01000; T5 R_enable=16'h0001.
//  2 Mem wait: hold mem_ready=0 for 5 cycles -> 6 cycles in T1, then T2.
//    Hold mem_ready=0 for 255 cycles -> fault=1; strobes 0 until clr.
//  3 MULDIV: op=5'b01111, Ra=3 Rb=4 -> LO_enable in T5, HI_enable in T6, instr_done only in T6, then T0.
//  4 Stop: assert stop during T2 -> the instruction completes and the unit returns to IDLE.
//    start&stop together in IDLE -> stays IDLE.
//  5 Halt/illegal: op=5'b11011 -> halted=1 after T3, start ignored.
//    op=5'b11111 -> NOP: instr_done in T3, then T0.
//  6 Reset: clr in T4 -> next cycle IDLE, all outputs 0, busy=0. Pending stop is cleared.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer and the Datapath: handshake inputs,
// IR, and every strobe the sequencer drives.
interface control_sequencer_if;
    logic        start;
    logic        stop;
    logic        mem_ready;
    logic [31:0] IR;

    logic        PC_out;
    logic        IncPC;
    logic        PC_enable;
    logic        MAR_enable;
    logic        Read;
    logic        MDR_enable;
    logic        MDR_out;
    logic        IR_enable;
    logic        Y_enable;
    logic        Z_enable;
    logic        ZLow_out;
    logic        ZHigh_out;
    logic        HI_enable;
    logic        LO_enable;
    logic [15:0] R_out;
    logic [15:0] R_enable;
    logic [4:0]  opcode;
    logic        busy;
    logic        halted;
    logic        fault;
    logic        instr_done;

    modport master (
        input  start, stop, mem_ready, IR,
        output PC_out, IncPC, PC_enable, MAR_enable, Read, MDR_enable, MDR_out, IR_enable,
               Y_enable, Z_enable, ZLow_out, ZHigh_out, HI_enable, LO_enable,
               R_out, R_enable, opcode, busy, halted, fault, instr_done
    );

    modport slave (
        output start, stop, mem_ready, IR,
        input  PC_out, IncPC, PC_enable, MAR_enable, Read, MDR_enable, MDR_out, IR_enable,
               Y_enable, Z_enable, ZLow_out, ZHigh_out, HI_enable, LO_enable,
               R_out, R_enable, opcode, busy, halted, fault, instr_done
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) with a timed memory handshake, then execute
// (T3-T6) for 3-register ALU ops, 2-register mul/div, nop and halt.
module control_sequencer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input logic                 clk,
    input logic                 clr,
    control_sequencer_if.master bus
);

    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StT0     = 4'd1;
    localparam logic [3:0] StT1     = 4'd2;
    localparam logic [3:0] StT2     = 4'd3;
    localparam logic [3:0] StT3     = 4'd4;
    localparam logic [3:0] StT4     = 4'd5;
    localparam logic [3:0] StT5     = 4'd6;
    localparam logic [3:0] StT6     = 4'd7;
    localparam logic [3:0] StHalted = 4'd8;
    localparam logic [3:0] StFault  = 4'd9;

    // Value the counter holds on the last tolerated wait cycle.
    localparam logic [CNT_W-1:0] WaitLast = CNT_W'(TIMEOUT - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stop_pend_q, stop_pend_d;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_md, is_halt;
    logic       in_busy;
    logic       finish;
    logic       unused_ir;

    assign op = bus.IR[31:27];
    assign ra = bus.IR[26:23];
    assign rb = bus.IR[22:19];
    assign rc = bus.IR[18:15];
    assign unused_ir = ^bus.IR[14:0];

    assign is_alu  = (op <= 5'd14);
    assign is_md   = (op == 5'd15) || (op == 5'd16);
    assign is_halt = (op == 5'd27);
    assign in_busy = (state_q >= StT0) && (state_q <= StT6);

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        stop_pend_d = stop_pend_q;
        finish      = 1'b0;
        if (in_busy && bus.stop) begin
            stop_pend_d = 1'b1;
        end
        case (state_q)
            StIdle: begin
                if (bus.start && !bus.stop) begin
                    state_d = StT0;
                end
            end
            StT0: state_d = StT1;
            StT1: begin
                // mem_ready is checked first so it wins on the final wait cycle.
                if (bus.mem_ready) begin
                    state_d = StT2;
                end else if (cnt_q == WaitLast) begin
                    state_d     = StFault;
                    stop_pend_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StT2: state_d = StT3;
            StT3: begin
                if (is_halt) begin
                    state_d     = StHalted;
                    stop_pend_d = 1'b0;
                end else if (is_alu || is_md) begin
                    state_d = StT4;
                end else begin
                    finish = 1'b1;
                end
            end
            StT4: state_d = StT5;
            StT5: begin
                if (is_md) begin
                    state_d = StT6;
                end else begin
                    finish = 1'b1;
                end
            end
            StT6:     finish = 1'b1;
            StHalted: state_d = StHalted;
            StFault:  state_d = StFault;
            default:  state_d = StIdle;
        endcase
        if (finish) begin
            state_d     = (stop_pend_q || bus.stop) ? StIdle : StT0;
            stop_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    always_comb begin
        bus.PC_out     = 1'b0;
        bus.IncPC      = 1'b0;
        bus.PC_enable  = 1'b0;
        bus.MAR_enable = 1'b0;
        bus.Read       = 1'b0;
        bus.MDR_enable = 1'b0;
        bus.MDR_out    = 1'b0;
        bus.IR_enable  = 1'b0;
        bus.Y_enable   = 1'b0;
        bus.Z_enable   = 1'b0;
        bus.ZLow_out   = 1'b0;
        bus.ZHigh_out  = 1'b0;
        bus.HI_enable  = 1'b0;
        bus.LO_enable  = 1'b0;
        bus.R_out      = '0;
        bus.R_enable   = '0;
        bus.opcode     = '0;
        bus.instr_done = 1'b0;
        case (state_q)
            StT0: begin
                bus.PC_out     = 1'b1;
                bus.MAR_enable = 1'b1;
                bus.IncPC      = 1'b1;
                bus.PC_enable  = 1'b1;
            end
            StT1: begin
                bus.Read       = 1'b1;
                bus.MDR_enable = 1'b1;
            end
            StT2: begin
                bus.MDR_out   = 1'b1;
                bus.IR_enable = 1'b1;
            end
            StT3: begin
                if (is_alu) begin
                    bus.R_out    = 16'h0001 << rb;
                    bus.Y_enable = 1'b1;
                end else if (is_md) begin
                    bus.R_out    = 16'h0001 << ra;
                    bus.Y_enable = 1'b1;
                end else begin
                    bus.instr_done = 1'b1;
                end
            end
            StT4: begin
                if (is_alu || is_md) begin
                    bus.R_out    = 16'h0001 << (is_alu ? rc : rb);
                    bus.Z_enable = 1'b1;
                    bus.opcode   = op;
                end
            end
            StT5: begin
                if (is_alu) begin
                    bus.ZLow_out   = 1'b1;
                    bus.R_enable   = 16'h0001 << ra;
                    bus.instr_done = 1'b1;
                end else if (is_md) begin
                    bus.ZLow_out  = 1'b1;
                    bus.LO_enable = 1'b1;
                end
            end
            StT6: begin
                if (is_md) begin
                    bus.ZHigh_out  = 1'b1;
                    bus.HI_enable  = 1'b1;
                    bus.instr_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy   = in_busy;
    assign bus.halted = (state_q == StHalted);
    assign bus.fault  = (state_q == StFault);

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven bench for control_sequencer: per-cycle expected outputs are queued as
// stimulus is driven and compared one cycle later by an independent checker.
module tb_control_sequencer;

    typedef struct packed {
        logic [15:0] r_out;
        logic [15:0] r_en;
        logic [4:0]  opc;
        logic pc_out, inc_pc, pc_en, mar_en, rd, mdr_en, mdr_out, ir_en;
        logic y_en, z_en, zlo, zhi, hi_en, lo_en, busy, halted, fault, done;
    } outs_t;

    typedef struct {
        outs_t e;
        int    phase;
        int    id;
    } exp_t;

    typedef struct {
        logic [31:0]     ir;
        int              n;
        outs_t [3:0]     e;
    } vec_t;

    localparam logic [6:0] MY  = 7'b1000000;
    localparam logic [6:0] MZ  = 7'b0100000;
    localparam logic [6:0] MZL = 7'b0010000;
    localparam logic [6:0] MZH = 7'b0001000;
    localparam logic [6:0] MLO = 7'b0000100;
    localparam logic [6:0] MHI = 7'b0000010;
    localparam logic [6:0] MD  = 7'b0000001;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    control_sequencer_if bus ();

    control_sequencer #(
        .TIMEOUT(255),
        .CNT_W  (8)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    exp_t  q[$];
    int    checks   = 0;
    int    failures = 0;
    int    phase    = 0;
    int    id_ctr   = 0;
    outs_t zero_e, t0e, t1e, t2e, halt_e, fault_e;
    vec_t  tab[8];

    function automatic outs_t ex(logic [15:0] ro, logic [15:0] ren, logic [4:0] opc,
                                 logic [6:0] m);
        outs_t o;
        o       = '0;
        o.r_out = ro;
        o.r_en  = ren;
        o.opc   = opc;
        o.y_en  = m[6];
        o.z_en  = m[5];
        o.zlo   = m[4];
        o.zhi   = m[3];
        o.lo_en = m[2];
        o.hi_en = m[1];
        o.done  = m[0];
        o.busy  = 1'b1;
        return o;
    endfunction

    function automatic logic [31:0] mk_ir(logic [4:0] op, logic [3:0] a, logic [3:0] b,
                                          logic [3:0] c);
        return {op, a, b, c, 15'h0};
    endfunction

    function automatic outs_t actual();
        outs_t o;
        o.r_out   = bus.R_out;
        o.r_en    = bus.R_enable;
        o.opc     = bus.opcode;
        o.pc_out  = bus.PC_out;
        o.inc_pc  = bus.IncPC;
        o.pc_en   = bus.PC_enable;
        o.mar_en  = bus.MAR_enable;
        o.rd      = bus.Read;
        o.mdr_en  = bus.MDR_enable;
        o.mdr_out = bus.MDR_out;
        o.ir_en   = bus.IR_enable;
        o.y_en    = bus.Y_enable;
        o.z_en    = bus.Z_enable;
        o.zlo     = bus.ZLow_out;
        o.zhi     = bus.ZHigh_out;
        o.hi_en   = bus.HI_enable;
        o.lo_en   = bus.LO_enable;
        o.busy    = bus.busy;
        o.halted  = bus.halted;
        o.fault   = bus.fault;
        o.done    = bus.instr_done;
        return o;
    endfunction

    // Scoreboard side: compare the oldest expectation just after each rising edge.
    always @(posedge clk) begin
        exp_t  x;
        outs_t a;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            a = actual();
            checks++;
            if (a !== x.e) begin
                failures++;
                $display("FAIL outputs phase=%0d step=%0d got=%h want=%h", x.phase, x.id,
                         a, x.e);
            end
        end
    end

    // Queue the outputs expected after the next rising edge, then advance to the falling edge.
    task automatic cyc(input outs_t e);
        exp_t x;
        x.e     = e;
        x.phase = phase;
        x.id    = id_ctr;
        id_ctr++;
        q.push_back(x);
        @(negedge clk);
    endtask

    task automatic go();
        bus.start = 1'b1;
        cyc(t0e);
        bus.start = 1'b0;
    endtask

    // Entered with the unit already expected in T0.
    task automatic run(input vec_t v, input int nwait, input bit stop_t0, input bit stop_t2,
                       input bit stop_last, input outs_t endx);
        bus.stop = stop_t0;
        cyc(t1e);
        bus.stop      = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (nwait) cyc(t1e);
        bus.mem_ready = 1'b1;
        cyc(t2e);
        bus.mem_ready = 1'b0;
        bus.stop      = stop_t2;
        for (int i = 0; i < v.n; i++) begin
            cyc(v.e[i]);
            bus.stop = 1'b0;
        end
        bus.stop = stop_last;
        cyc(endx);
        bus.stop = 1'b0;
    endtask

    initial begin
        vec_t hv;

        zero_e        = '0;
        t0e           = '0;
        t0e.pc_out    = 1'b1;
        t0e.mar_en    = 1'b1;
        t0e.inc_pc    = 1'b1;
        t0e.pc_en     = 1'b1;
        t0e.busy      = 1'b1;
        t1e           = '0;
        t1e.rd        = 1'b1;
        t1e.mdr_en    = 1'b1;
        t1e.busy      = 1'b1;
        t2e           = '0;
        t2e.mdr_out   = 1'b1;
        t2e.ir_en     = 1'b1;
        t2e.busy      = 1'b1;
        halt_e        = '0;
        halt_e.halted = 1'b1;
        fault_e       = '0;
        fault_e.fault = 1'b1;

        tab[0] = '{ir: 32'h40090000, n: 3,
                   e: {outs_t'('0), ex(16'h0000, 16'h0001, 5'd0, MZL | MD),
                       ex(16'h0004, 16'h0000, 5'b01000, MZ), ex(16'h0002, 16'h0000, 5'd0, MY)}};
        tab[1] = '{ir: mk_ir(5'b01111, 4'd3, 4'd4, 4'd0), n: 4,
                   e: {ex(16'h0000, 16'h0000, 5'd0, MZH | MHI | MD),
                       ex(16'h0000, 16'h0000, 5'd0, MZL | MLO),
                       ex(16'h0010, 16'h0000, 5'b01111, MZ), ex(16'h0008, 16'h0000, 5'd0, MY)}};
        tab[2] = '{ir: mk_ir(5'b10000, 4'd15, 4'd0, 4'd9), n: 4,
                   e: {ex(16'h0000, 16'h0000, 5'd0, MZH | MHI | MD),
                       ex(16'h0000, 16'h0000, 5'd0, MZL | MLO),
                       ex(16'h0001, 16'h0000, 5'b10000, MZ), ex(16'h8000, 16'h0000, 5'd0, MY)}};
        tab[3] = '{ir: mk_ir(5'b00000, 4'd15, 4'd14, 4'd13), n: 3,
                   e: {outs_t'('0), ex(16'h0000, 16'h8000, 5'd0, MZL | MD),
                       ex(16'h2000, 16'h0000, 5'b00000, MZ), ex(16'h4000, 16'h0000, 5'd0, MY)}};
        tab[4] = '{ir: mk_ir(5'b01110, 4'd5, 4'd6, 4'd7), n: 3,
                   e: {outs_t'('0), ex(16'h0000, 16'h0020, 5'd0, MZL | MD),
                       ex(16'h0080, 16'h0000, 5'b01110, MZ), ex(16'h0040, 16'h0000, 5'd0, MY)}};
        tab[5] = '{ir: mk_ir(5'b11111, 4'd1, 4'd2, 4'd3), n: 1,
                   e: {outs_t'('0), outs_t'('0), outs_t'('0), ex(16'h0, 16'h0, 5'd0, MD)}};
        tab[6] = '{ir: mk_ir(5'b11010, 4'd4, 4'd5, 4'd6), n: 1,
                   e: {outs_t'('0), outs_t'('0), outs_t'('0), ex(16'h0, 16'h0, 5'd0, MD)}};
        tab[7] = '{ir: mk_ir(5'b10001, 4'd7, 4'd8, 4'd9), n: 1,
                   e: {outs_t'('0), outs_t'('0), outs_t'('0), ex(16'h0, 16'h0, 5'd0, MD)}};

        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.mem_ready = 1'b0;
        bus.IR        = '0;
        clr           = 1'b1;
        @(negedge clk);
        phase = 1;
        cyc(zero_e);
        cyc(zero_e);
        clr = 1'b0;
        cyc(zero_e);

        // Each table entry: fetch with a small wait, execute, stop on the final step.
        for (int i = 0; i < 8; i++) begin
            phase  = 10 + i;
            bus.IR = tab[i].ir;
            go();
            run(tab[i], (i == 1) ? 5 : (i % 3), 1'b0, 1'b0, 1'b1, zero_e);
            cyc(zero_e);
        end

        // Back-to-back instruction, then stop raised in T0 is remembered until the end.
        phase  = 20;
        bus.IR = tab[0].ir;
        go();
        run(tab[0], 0, 1'b0, 1'b0, 1'b0, t0e);
        run(tab[0], 0, 1'b1, 1'b0, 1'b0, zero_e);

        // Stop during T2 of a mul: instruction completes, then IDLE.
        phase  = 21;
        bus.IR = tab[1].ir;
        go();
        run(tab[1], 0, 1'b0, 1'b1, 1'b0, zero_e);

        // start and stop together in IDLE.
        phase     = 22;
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        cyc(zero_e);
        cyc(zero_e);
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        // mem_ready arriving on the last tolerated wait cycle still reaches T2.
        phase  = 23;
        bus.IR = tab[3].ir;
        go();
        run(tab[3], 254, 1'b0, 1'b0, 1'b1, zero_e);

        // 255 cycles without mem_ready: FAULT, which ignores start until clr.
        phase = 24;
        go();
        bus.mem_ready = 1'b0;
        cyc(t1e);
        repeat (254) cyc(t1e);
        cyc(fault_e);
        bus.start = 1'b1;
        cyc(fault_e);
        cyc(fault_e);
        bus.start = 1'b0;
        clr       = 1'b1;
        cyc(zero_e);
        clr = 1'b0;
        cyc(zero_e);

        // Halt: instr_done in T3, then HALTED, sticky until clr.
        phase   = 25;
        hv.ir   = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);
        hv.n    = 1;
        hv.e    = '0;
        hv.e[0] = ex(16'h0, 16'h0, 5'd0, MD);
        bus.IR  = hv.ir;
        go();
        run(hv, 0, 1'b0, 1'b0, 1'b0, halt_e);
        bus.start = 1'b1;
        cyc(halt_e);
        cyc(halt_e);
        bus.start = 1'b0;
        clr       = 1'b1;
        cyc(zero_e);
        clr = 1'b0;

        // clr in T4 with a stop pending: aborts, and the pending stop is forgotten.
        phase  = 26;
        bus.IR = tab[0].ir;
        go();
        bus.stop = 1'b1;
        cyc(t1e);
        bus.stop      = 1'b0;
        bus.mem_ready = 1'b1;
        cyc(t2e);
        bus.mem_ready = 1'b0;
        cyc(tab[0].e[0]);
        cyc(tab[0].e[1]);
        clr = 1'b1;
        cyc(zero_e);
        clr = 1'b0;
        cyc(zero_e);
        go();
        run(tab[0], 0, 1'b0, 1'b0, 1'b0, t0e);
        clr = 1'b1;
        cyc(zero_e);
        clr = 1'b0;

        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
